// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared bus/reset defines plus slot type and helpers for the fetch stage.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define InstAddrBus 31:0
`define InstBus 31:0
`define CpuResetAddr 32'h0000_0000
`define NOP 32'h0000_0013
`define RstEnable 1'b1
`define PcStep 32'd4
`endif

package inst_fetch_pkg;
    typedef logic [`InstAddrBus] addr_t;
    typedef logic [`InstBus] inst_t;
    localparam addr_t RESET_ADDR = `CpuResetAddr;
    localparam inst_t NOP_INST = `NOP;
    localparam addr_t PC_STEP = `PcStep;
    localparam logic RST_ENABLE = `RstEnable;

    typedef struct packed {
        addr_t addr;
        inst_t data;
        logic  ready;
    } slot_t;

    function automatic addr_t align_word(input addr_t a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_queue.sv
// fetch_queue: in-order fetch slots; entries are allocated at grant and filled in order by responses.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             alloc_i,
    input  addr_t            alloc_addr_i,
    input  logic             fill_i,
    input  inst_t            fill_data_i,
    input  logic             pop_i,
    output slot_t            head_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int IW = CNT_W - 1;
    // Entries between rd and fill are ready; between fill and wr they await data.
    logic [CNT_W-1:0] wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;
    addr_t addr_q [DEPTH];
    inst_t data_q [DEPTH];

    always_comb begin
        wr_d   = clear_i ? '0 : wr_q + CNT_W'(alloc_i);
        fill_d = clear_i ? '0 : fill_q + CNT_W'(fill_i);
        rd_d   = clear_i ? '0 : rd_q + CNT_W'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            fill_q <= '0;
            rd_q   <= '0;
        end else begin
            wr_q   <= wr_d;
            fill_q <= fill_d;
            rd_q   <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_i) addr_q[wr_q[IW-1:0]] <= alloc_addr_i;
        if (fill_i) data_q[fill_q[IW-1:0]] <= fill_data_i;
    end

    assign head_o  = '{addr: addr_q[rd_q[IW-1:0]], data: data_q[rd_q[IW-1:0]], ready: fill_q != rd_q};
    assign count_o = wr_q - rd_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, in-order imem requests, response queue and IF/ID output register.
// Define FETCH_BYPASS_EN to forward a response straight to the output when nothing is buffered.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    logic             rst_on, gnt, resp, fill, advance, hold, bypass, pop;
    logic [CNT_W-1:0] occ, out_q, out_d, drop_q, drop_d;
    addr_t            pc_q, pc_d, inst_addr_q, inst_addr_d;
    inst_t            inst_q, inst_d;
    logic             valid_q, valid_d;
    slot_t            head;

    assign rst_on     = rst_i == RST_ENABLE;
    assign imem_req_o = !rst_on && !flush_i && drop_q == '0 && occ < CNT_W'(FIFO_DEPTH);
    assign gnt        = imem_req_o && imem_gnt_i;
    assign resp       = imem_rvalid_i && drop_q == '0;
    assign fill       = resp && !flush_i;
    assign advance    = !stall_i && !flush_i;
    assign hold       = stall_i && !flush_i;
`ifdef FETCH_BYPASS_EN
    assign bypass = advance && fill && !head.ready;
`else
    assign bypass = 1'b0;
`endif
    assign pop = (advance && head.ready) || bypass;

    fetch_queue #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_on),
        .clear_i     (flush_i),
        .alloc_i     (gnt),
        .alloc_addr_i(pc_q),
        .fill_i      (fill),
        .fill_data_i (imem_rdata_i),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (occ)
    );

    // On flush every in-flight response becomes a drop; outstanding is 0 whenever drop_q is nonzero.
    always_comb begin
        pc_d        = flush_i ? align_word(flush_addr_i) : gnt ? pc_q + PC_STEP : pc_q;
        out_d       = flush_i ? '0 : out_q + CNT_W'(gnt) - CNT_W'(resp);
        drop_d      = flush_i ? drop_q + out_q - CNT_W'(imem_rvalid_i)
                              : drop_q - CNT_W'(imem_rvalid_i && drop_q != '0);
        inst_addr_d = pop ? head.addr : inst_addr_q;
        inst_d      = pop ? (head.ready ? head.data : imem_rdata_i) : hold ? inst_q : NOP_INST;
        valid_d     = pop || (hold && valid_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_on) begin
            pc_q        <= RESET_ADDR;
            out_q       <= '0;
            drop_q      <= '0;
            inst_addr_q <= RESET_ADDR;
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            inst_addr_q <= inst_addr_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
endmodule
